// File: rtl/adc_pkg.sv
// Shared constants for the ADC sample framing path.
package adc_pkg;

  localparam int unsigned ADC_WIDTH = 10;
  localparam int unsigned ADC_DEPTH = 4;

  // Framer FSM encoding
  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_SHIFT   = 2'd1;
  localparam logic [1:0] S_CAPTURE = 2'd2;

endpackage

// File: rtl/adc_sample_framer_if.sv
// Valid/ready sample stream between the framer and the sample consumer.
interface adc_sample_framer_if
  import adc_pkg::*;
#(
  parameter int unsigned WIDTH = ADC_WIDTH
) ();

  logic [WIDTH-1:0] data;
  logic             valid;
  logic             ready;

  modport master (output data, output valid, input  ready);
  modport slave  (input  data, input  valid, output ready);

endinterface

// File: rtl/adc_sample_fifo.sv
// Small sample FIFO: registered pointers and occupancy, head word read combinationally.
module adc_sample_fifo
  import adc_pkg::*;
#(
  parameter int unsigned WIDTH = ADC_WIDTH,
  parameter int unsigned DEPTH = ADC_DEPTH
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  output logic                       full,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] level
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned LW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [LW-1:0]    r_level;
  logic             w_push_ok;
  logic             w_pop_ok;

  assign empty     = (r_level == '0);
  assign full      = (r_level == LW'(DEPTH));
  assign w_pop_ok  = pop & ~empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle
  assign w_push_ok = push & (~full | w_pop_ok);
  // Masked while empty so stale entries never reach the stream
  assign dout      = empty ? '0 : r_mem[r_rd_ptr];
  assign level     = r_level;

  // Storage write; contents are discarded on reset by clearing the pointers
  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap modulo DEPTH
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_pop_ok) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      if (w_push_ok && !w_pop_ok) begin
        r_level <= r_level + LW'(1);
      end else if (!w_push_ok && w_pop_ok) begin
        r_level <= r_level - LW'(1);
      end
    end
  end

endmodule

// File: rtl/adc_sample_framer.sv
// Frame sequencer for the ADC shift chain: shifts WIDTH cycles, captures the
// parallel word into a FIFO and streams it out, flagging dropped samples.
module adc_sample_framer
  import adc_pkg::*;
#(
  parameter int unsigned WIDTH = ADC_WIDTH,
  parameter int unsigned DEPTH = ADC_DEPTH
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       start_i,
  input  logic [WIDTH-1:0]           par_i,
  output logic                       shift_en_o,
  output logic                       busy_o,
  adc_sample_framer_if.master        m_if,
  output logic                       overrun_o,
  input  logic                       clr_ovr_i,
  output logic [$clog2(DEPTH+1)-1:0] level_o
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [CW-1:0]    r_cnt;
  logic [CW-1:0]    w_cnt_nxt;
  logic             r_shift_en;
  logic             r_busy;
  logic             r_overrun;
  logic             w_push;
  logic             w_pop;
  logic             w_full;
  logic             w_empty;
  logic             w_ovr_set;
  logic [WIDTH-1:0] w_dout;

  // Next-state and shift counter logic
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (start_i) begin
          w_state_nxt = S_SHIFT;
          w_cnt_nxt   = '0;
        end
      end
      S_SHIFT: begin
        if (r_cnt == CW'(WIDTH - 1)) begin
          w_state_nxt = S_CAPTURE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt   = r_cnt + CW'(1);
        end
      end
      S_CAPTURE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // State register with registered shift enable and busy derived from next state
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_shift_en <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_shift_en <= (w_state_nxt == S_SHIFT);
      r_busy     <= (w_state_nxt != S_IDLE);
    end
  end

  assign w_push    = (r_state == S_CAPTURE);
  assign w_pop     = ~w_empty & m_if.ready;
  assign w_ovr_set = w_push & w_full & ~w_pop;

  // Sticky overrun flag; a new drop wins over a same-cycle clear
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_overrun <= 1'b0;
    end else if (w_ovr_set) begin
      r_overrun <= 1'b1;
    end else if (clr_ovr_i) begin
      r_overrun <= 1'b0;
    end
  end

  adc_sample_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (w_push),
    .din     (par_i),
    .full    (w_full),
    .pop     (w_pop),
    .dout    (w_dout),
    .empty   (w_empty),
    .level   (level_o)
  );

  assign shift_en_o = r_shift_en;
  assign busy_o     = r_busy;
  assign overrun_o  = r_overrun;
  assign m_if.data  = w_dout;
  assign m_if.valid = ~w_empty;

endmodule
